tx_beamformer_8: RTL and testbench

Transmit-side counterpart of the 8-element adaptive receive beamformer. Takes one complex baseband symbol and the 8 complex weights produced by the adaptive weight-update path, and produces the 8 per-antenna transmit samples `y_k = w_k · s`. Weights are double-buffered, so a new weight set never changes in the middle of a symbol. One time-multiplexed complex multiplier serves all 8 elements, sequenced by a small FSM.

---
 rtl/tx_beamformer_8.sv | 141 ++++++++++++++
 tb/tb_tx_beamformer_8.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_beamformer_8.sv
// 8-element transmit beamformer: y_k = w_k * s on one shared complex multiplier, double-buffered weights.
// Latency: accept edge E0, yo1..yo8 written on E1..E8 with out_valid on E8; s_ready low for the whole run.
module tx_beamformer_8 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [35:0] s_in,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        w_load,
  input  logic [35:0] win1,
  input  logic [35:0] win2,
  input  logic [35:0] win3,
  input  logic [35:0] win4,
  input  logic [35:0] win5,
  input  logic [35:0] win6,
  input  logic [35:0] win7,
  input  logic [35:0] win8,
  output logic [35:0] yo1,
  output logic [35:0] yo2,
  output logic [35:0] yo3,
  output logic [35:0] yo4,
  output logic [35:0] yo5,
  output logic [35:0] yo6,
  output logic [35:0] yo7,
  output logic [35:0] yo8,
  output logic        out_valid,
  output logic        w_pending
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state;
  logic [2:0]  idx;
  logic [35:0] sym;
  logic        pending;
  logic [35:0] shadow [8];
  logic [35:0] active [8];
  logic [35:0] yo     [8];
  logic [35:0] win    [8];

  assign win[0] = win1;
  assign win[1] = win2;
  assign win[2] = win3;
  assign win[3] = win4;
  assign win[4] = win5;
  assign win[5] = win6;
  assign win[6] = win7;
  assign win[7] = win8;

  assign yo1 = yo[0];
  assign yo2 = yo[1];
  assign yo3 = yo[2];
  assign yo4 = yo[3];
  assign yo5 = yo[4];
  assign yo6 = yo[5];
  assign yo7 = yo[6];
  assign yo8 = yo[7];

  assign s_ready   = (state == IDLE) & rst_n;
  assign w_pending = pending;

  logic               accept;
  logic signed [17:0] wi, wq, si, sq;
  logic signed [35:0] m_ii, m_qq, m_iq, m_qi;
  logic signed [36:0] p_i, p_q;
  logic        [35:0] y_elem;

  assign accept = (state == IDLE) & s_valid;

  assign wi = active[idx][35:18];
  assign wq = active[idx][17:0];
  assign si = sym[35:18];
  assign sq = sym[17:0];

  assign m_ii = wi * si;
  assign m_qq = wq * sq;
  assign m_iq = wi * sq;
  assign m_qi = wq * si;

  assign p_i = 37'(m_ii) - 37'(m_qq);
  assign p_q = 37'(m_iq) + 37'(m_qi);

  // Round half toward +inf, then clamp to the Q1.17 range.
  function automatic logic [17:0] rnd_sat(input logic signed [36:0] p);
    logic signed [37:0] t;
    t = (38'(p) + 38'sd65536) >>> 17;
    if (t > 38'sd131071)
      rnd_sat = 18'h1ffff;
    else if (t < -38'sd131072)
      rnd_sat = 18'h20000;
    else
      rnd_sat = t[17:0];
  endfunction

  assign y_elem = {rnd_sat(p_i), rnd_sat(p_q)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= 3'd0;
      sym       <= 36'd0;
      pending   <= 1'b0;
      out_valid <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        shadow[k] <= 36'd0;
        active[k] <= 36'd0;
        yo[k]     <= 36'd0;
      end
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            sym   <= s_in;
            idx   <= 3'd0;
            state <= RUN;
            // Commit reads the pre-edge shadow, so a same-edge load lands for the next symbol.
            if (pending) begin
              for (int k = 0; k < 8; k++) active[k] <= shadow[k];
              pending <= 1'b0;
            end
          end
        end
        RUN: begin
          yo[idx] <= y_elem;
          idx     <= idx + 3'd1;
          if (idx == 3'd7) begin
            state     <= IDLE;
            out_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      if (w_load) begin
        for (int k = 0; k < 8; k++) shadow[k] <= win[k];
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tx_beamformer_8.sv
// Bench for tx_beamformer_8: directed and random symbols against an arithmetic reference model.
module tb_tx_beamformer_8;

  logic        clk;
  logic        rst_n;
  logic [35:0] s_in;
  logic        s_valid;
  logic        s_ready;
  logic        w_load;
  logic [35:0] win1, win2, win3, win4, win5, win6, win7, win8;
  logic [35:0] yo1, yo2, yo3, yo4, yo5, yo6, yo7, yo8;
  logic        out_valid;
  logic        w_pending;

  logic [35:0] win_a [8];
  logic [35:0] yo_a  [8];

  assign win1 = win_a[0];
  assign win2 = win_a[1];
  assign win3 = win_a[2];
  assign win4 = win_a[3];
  assign win5 = win_a[4];
  assign win6 = win_a[5];
  assign win7 = win_a[6];
  assign win8 = win_a[7];

  assign yo_a[0] = yo1;
  assign yo_a[1] = yo2;
  assign yo_a[2] = yo3;
  assign yo_a[3] = yo4;
  assign yo_a[4] = yo5;
  assign yo_a[5] = yo6;
  assign yo_a[6] = yo7;
  assign yo_a[7] = yo8;

  tx_beamformer_8 dut (
    .clk(clk), .rst_n(rst_n), .s_in(s_in), .s_valid(s_valid), .s_ready(s_ready),
    .w_load(w_load),
    .win1(win1), .win2(win2), .win3(win3), .win4(win4),
    .win5(win5), .win6(win6), .win7(win7), .win8(win8),
    .yo1(yo1), .yo2(yo2), .yo3(yo3), .yo4(yo4),
    .yo5(yo5), .yo6(yo6), .yo7(yo7), .yo8(yo8),
    .out_valid(out_valid), .w_pending(w_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference state: what the weight banks should hold, tracked from the stimulus alone.
  logic [35:0] m_active [8];
  logic [35:0] m_shadow [8];
  logic        m_pend;
  logic [35:0] nw [8];

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic [35:0] cx(input int i, input int q);
    return {18'(i), 18'(q)};
  endfunction

  function automatic logic [17:0] q17(input longint p);
    longint r;
    r = (p + 65536) >>> 17;
    if (r > 131071) r = 131071;
    if (r < -131072) r = -131072;
    return r[17:0];
  endfunction

  function automatic logic [35:0] cmul(input logic [35:0] w, input logic [35:0] s);
    longint wi, wq, si, sq;
    wi = longint'($signed(w[35:18]));
    wq = longint'($signed(w[17:0]));
    si = longint'($signed(s[35:18]));
    sq = longint'($signed(s[17:0]));
    return {q17(wi * si - wq * sq), q17(wi * sq + wq * si)};
  endfunction

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic randw;
    for (int i = 0; i < 8; i++) nw[i] = {18'($urandom), 18'($urandom)};
  endtask

  task automatic load_w;
    win_a  = nw;
    w_load = 1'b1;
    tick;
    w_load   = 1'b0;
    m_shadow = nw;
    m_pend   = 1'b1;
    chk1("pend_after_load", w_pending, 1'b1);
  endtask

  // One symbol through the pipe; optional weight load on the accept edge or on run edge load_at.
  task automatic run_sym(input logic [35:0] s, input bit load_same, input int load_at);
    logic [35:0] used [8];
    chk1("rdy_idle", s_ready, 1'b1);
    s_in    = s;
    s_valid = 1'b1;
    if (load_same) begin
      win_a  = nw;
      w_load = 1'b1;
    end
    tick;
    if (m_pend) begin
      m_active = m_shadow;
      m_pend   = 1'b0;
    end
    used = m_active;
    if (load_same) begin
      m_shadow = nw;
      m_pend   = 1'b1;
    end
    s_valid = 1'b0;
    w_load  = 1'b0;
    chk1("rdy_run", s_ready, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      if (k == load_at) begin
        win_a  = nw;
        w_load = 1'b1;
      end
      tick;
      if (k == load_at) begin
        w_load   = 1'b0;
        m_shadow = nw;
        m_pend   = 1'b1;
      end
      if (k < 8) chk1("ov_early", out_valid, 1'b0);
    end
    chk1("ov_e8", out_valid, 1'b1);
    for (int i = 0; i < 8; i++) chk($sformatf("y%0d", i + 1), yo_a[i], cmul(used[i], s));
    chk1("pend_e8", w_pending, m_pend);
    tick;
    chk1("ov_e9", out_valid, 1'b0);
    chk1("rdy_e9", s_ready, 1'b1);
  endtask

  initial begin
    int n_acc, n_ov, last_acc;
    bit acc_now;
    logic [35:0] q[$];
    logic [35:0] es;

    rst_n   = 1'b0;
    s_in    = '0;
    s_valid = 1'b0;
    w_load  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      win_a[i]    = '0;
      m_active[i] = '0;
      m_shadow[i] = '0;
    end
    m_pend = 1'b0;
    #12;
    chk1("rdy_in_reset", s_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    chk1("rst_rdy", s_ready, 1'b1);
    chk1("rst_ov", out_valid, 1'b0);
    chk1("rst_pend", w_pending, 1'b0);
    for (int i = 0; i < 8; i++) chk($sformatf("rst_y%0d", i + 1), yo_a[i], 36'd0);

    // Basic multiply
    for (int i = 0; i < 8; i++) nw[i] = cx(65536, 0);
    load_w;
    run_sym(cx(65536, 0), 0, 0);
    chk("basic_y1", yo_a[0], cx(32768, 0));
    chk("basic_y8", yo_a[7], cx(32768, 0));
    chk1("basic_pend", w_pending, 1'b0);

    // Sign, saturation, rounding corners
    nw[0] = cx(-131072, 0);
    nw[1] = cx(1, 0);
    nw[2] = cx(0, 65536);
    nw[3] = cx(65536, 0);
    nw[4] = cx(65536, -65536);
    nw[5] = cx(131071, 131071);
    nw[6] = cx(-131072, -131072);
    nw[7] = cx(-1, 1);
    load_w;
    run_sym(cx(-131072, 0), 0, 0);
    chk("sat_y1", yo_a[0], cx(131071, 0));
    run_sym(cx(65536, 0), 0, 0);
    chk("rnd_up_y2", yo_a[1], cx(1, 0));
    chk("cplx_y3", yo_a[2], cx(0, 32768));
    run_sym(cx(-65536, 0), 0, 0);
    chk("rnd_neg_y2", yo_a[1], cx(0, 0));
    run_sym(cx(0, 65536), 0, 0);
    chk("cplx_y5", yo_a[4], cx(32768, 32768));

    // Double buffer: load during run, commit on next accept, load on accept edge
    randw;
    load_w;
    randw;
    run_sym({18'($urandom), 18'($urandom)}, 0, 3);
    chk1("dbuf_pend_s1", w_pending, 1'b1);
    run_sym({18'($urandom), 18'($urandom)}, 0, 0);
    chk1("dbuf_pend_s2", w_pending, 1'b0);
    randw;
    run_sym({18'($urandom), 18'($urandom)}, 1, 0);
    chk1("dbuf_pend_s3", w_pending, 1'b1);
    run_sym({18'($urandom), 18'($urandom)}, 0, 0);
    chk1("dbuf_pend_s4", w_pending, 1'b0);

    // Random weights and symbols
    for (int r = 0; r < 6; r++) begin
      randw;
      load_w;
      randw;
      run_sym({18'($urandom), 18'($urandom)}, bit'($urandom_range(0, 1)), int'($urandom_range(0, 9)));
    end

    // Back-to-back with s_valid held high
    n_acc    = 0;
    n_ov     = 0;
    last_acc = -1;
    s_in     = {18'($urandom), 18'($urandom)};
    s_valid  = 1'b1;
    for (int c = 0; c < 400 && n_ov < 16; c++) begin
      acc_now = 1'b0;
      if (out_valid) begin
        n_ov++;
        es = (q.size() > 0) ? q.pop_front() : 36'd0;
        for (int i = 0; i < 8; i++) chk($sformatf("b2b_y%0d", i + 1), yo_a[i], cmul(m_active[i], es));
      end
      if (s_ready && s_valid) begin
        if (last_acc >= 0) chki("b2b_gap", c - last_acc, 9);
        last_acc = c;
        if (m_pend) begin
          m_active = m_shadow;
          m_pend   = 1'b0;
        end
        q.push_back(s_in);
        n_acc++;
        acc_now = 1'b1;
      end
      tick;
      if (acc_now) begin
        s_in = {18'($urandom), 18'($urandom)};
        if (n_acc == 16) s_valid = 1'b0;
      end
    end
    s_valid = 1'b0;
    chki("b2b_accepts", n_acc, 16);
    chki("b2b_outputs", n_ov, 16);
    chki("b2b_leftover", q.size(), 0);
    tick;

    // Reset in the middle of a run
    randw;
    load_w;
    s_in    = {18'($urandom), 18'($urandom)};
    s_valid = 1'b1;
    tick;
    s_valid = 1'b0;
    tick;
    tick;
    tick;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) chk($sformatf("mid_rst_y%0d", i + 1), yo_a[i], 36'd0);
    chk1("mid_rst_pend", w_pending, 1'b0);
    chk1("mid_rst_rdy", s_ready, 1'b0);
    chk1("mid_rst_ov", out_valid, 1'b0);
    for (int i = 0; i < 8; i++) begin
      m_active[i] = '0;
      m_shadow[i] = '0;
    end
    m_pend = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk1("post_rst_rdy", s_ready, 1'b1);
    begin
      int ov_seen;
      ov_seen = 0;
      for (int c = 0; c < 12; c++) begin
        tick;
        if (out_valid) ov_seen++;
      end
      chki("aborted_no_ov", ov_seen, 0);
    end
    run_sym({18'($urandom), 18'($urandom)}, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
